// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_pkg
// Purpose  : Shared widths, arbiter state type and one-hot to select helper
// Revision : 1.0 - initial release
// ============================================================================
package mux_sel_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [SEL_W-1:0] onehot_to_sel(input logic [NCH-1:0] oh);
    logic [SEL_W-1:0] s;
    s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (oh[i]) s = s | SEL_W'(i);
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin winner search starting after 'last'
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import mux_sel_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] win_idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // Walk from lowest to highest priority so the nearest requester wins last.
  always_comb begin
    win_idx = last;
    cand    = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) win_idx = cand;
    end
    any = |req;
  end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Round-robin arbiter with hold budget driving a 4:1 mux select
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter
  import mux_sel_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   grant,
  output logic             valid,
  output logic             timeout
);

  localparam int               CNT_W     = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NCH-1:0]   grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] win_idx;
  logic             win_any;
  logic             rel_done, rel_drop, rel_limit, release_now, load;

  rr_pick u_pick (
    .req     (req),
    .last    (last_q),
    .win_idx (win_idx),
    .any     (win_any)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    valid_d     = valid_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    load        = 1'b0;
    rel_done    = done;
    rel_drop    = ~req[sel_q];
    rel_limit   = (cnt_q == CNT_LIMIT);
    release_now = rel_done | rel_drop | rel_limit;

    case (state_q)
      IDLE: begin
        load = win_any;
      end
      GRANT: begin
        if (release_now) begin
          timeout_d = rel_limit & ~rel_done & ~rel_drop;
          if (win_any) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // last_q always equals the current owner, so re-arbitration on release
    // already treats the released channel as lowest priority.
    if (load) begin
      grant_d = NCH'(1) << win_idx;
      sel_d   = onehot_to_sel(grant_d);
      last_d  = sel_d;
      valid_d = 1'b1;
      cnt_d   = '0;
      state_d = GRANT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= SEL_W'(NCH - 1);
      sel_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule
`default_nettype wire
